// File: rtl/zoom_pkg.sv
`default_nettype none
// ============================================================================
// Module  : zoom_pkg
// Brief   : Shared constants, width helpers and state encoding for the
//           zoom-in / zoom-out image scaling paths.
// Revision: 1.0 - initial release
// ============================================================================
package zoom_pkg;

  // Default frame geometry and pixel depth.
  localparam int LARGURA_DEF = 4;
  localparam int ALTURA_DEF  = 4;
  localparam int ZOOM_DEF    = 2;
  localparam int PIX_W_DEF   = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  // Width of an index/counter covering n entries, never narrower than 1 bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // A ZOOM x ZOOM block sum of pix_w-bit pixels needs 2*log2(ZOOM) extra bits.
  function automatic int acc_width(input int pix_w, input int zoom);
    return pix_w + 2 * clog2(zoom);
  endfunction

  // Frame tracking state shared by both scaling directions.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } zoom_state_t;

endpackage
`default_nettype wire

// File: rtl/zoom_acc_bank.sv
`default_nettype none
// ============================================================================
// Module  : zoom_acc_bank
// Brief   : One partial-sum register per output column. Presents the sum of
//           the selected entry and the incoming pixel, and on write either
//           reloads the entry with the pixel or stores that sum.
// Revision: 1.0 - initial release
// ============================================================================
module zoom_acc_bank
  import zoom_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int ACC_W = 10,
  parameter int PIX_W = 8,
  localparam int IDX_W = idx_width(DEPTH)
) (
  input  logic             clock,
  input  logic [IDX_W-1:0] index,
  input  logic             write,
  input  logic             load,
  input  logic [PIX_W-1:0] pixel,
  output logic [ACC_W-1:0] sum
);

  // Contents are always overwritten by the first pixel of a block, so no reset.
  logic [ACC_W-1:0] acc [DEPTH];

  // Running block sum including the pixel currently presented.
  always_comb begin
    sum = acc[index] + ACC_W'(pixel);
  end

  // Start a new block sum or extend the existing one.
  always_ff @(posedge clock) begin
    if (write) begin
      acc[index] <= load ? ACC_W'(pixel) : sum;
    end
  end

endmodule
`default_nettype wire

// File: rtl/avg_zoom_out.sv
`default_nettype none
// ============================================================================
// Module  : avg_zoom_out
// Brief   : Streaming box-filter downscaler. Each output pixel is the
//           round-half-up mean of a ZOOM x ZOOM input block, emitted through
//           a single output register with valid/ready flow control.
// Revision: 1.0 - initial release
// ============================================================================
module avg_zoom_out
  import zoom_pkg::*;
#(
  parameter int LARGURA = LARGURA_DEF,
  parameter int ALTURA  = ALTURA_DEF,
  parameter int ZOOM    = ZOOM_DEF,
  parameter int PIX_W   = PIX_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_eof,
  output logic             err_sof
);

  localparam int ZL       = clog2(ZOOM);
  localparam int NLARGURA = LARGURA / ZOOM;
  localparam int NALTURA  = ALTURA / ZOOM;
  localparam int ACC_W    = PIX_W + 2 * ZL;
  localparam int COL_W    = idx_width(LARGURA);
  localparam int ROW_W    = idx_width(ALTURA);
  localparam int IDX_W    = idx_width(NLARGURA);

  localparam logic [COL_W-1:0] COL_LAST = COL_W'(LARGURA - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ALTURA - 1);
  localparam logic [COL_W-1:0] COL_MASK = COL_W'(ZOOM - 1);
  localparam logic [ROW_W-1:0] ROW_MASK = ROW_W'(ZOOM - 1);
  localparam logic [COL_W-1:0] BLK_COL_LAST = COL_W'(NLARGURA - 1);
  localparam logic [ROW_W-1:0] BLK_ROW_LAST = ROW_W'(NALTURA - 1);
  // Half of the block size; evaluates to zero for ZOOM = 1 (passthrough).
  localparam logic [ACC_W-1:0] ROUND = ACC_W'((2 ** (2 * ZL)) / 2);

  zoom_state_t      state, state_next;
  logic [ROW_W-1:0] linha, linha_next;
  logic [COL_W-1:0] coluna, coluna_next;

  logic             accept;
  logic             process;
  logic [ROW_W-1:0] pos_l;
  logic [COL_W-1:0] pos_c;
  logic             first_pix;
  logic             last_pix;
  logic             err_det;
  logic [IDX_W-1:0] acc_index;
  logic [ACC_W-1:0] acc_sum;
  logic [ACC_W-1:0] block_sum;
  logic [PIX_W-1:0] avg;

  // Only one output register, so input may advance whenever it is free or draining.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  // A sof pixel always restarts at (0,0); without sof, IDLE discards the pixel.
  assign process = accept & ((state == RUN) | in_sof);
  assign pos_l   = (in_sof || state == IDLE) ? '0 : linha;
  assign pos_c   = (in_sof || state == IDLE) ? '0 : coluna;

  assign first_pix = ((pos_c & COL_MASK) == '0) && ((pos_l & ROW_MASK) == '0);
  assign last_pix  = ((pos_c & COL_MASK) == COL_MASK) && ((pos_l & ROW_MASK) == ROW_MASK);
  assign err_det   = accept & in_sof & (state == RUN) & ((linha != '0) | (coluna != '0));
  assign acc_index = IDX_W'(pos_c >> ZL);

  zoom_acc_bank #(
    .DEPTH(NLARGURA),
    .ACC_W(ACC_W),
    .PIX_W(PIX_W)
  ) u_acc_bank (
    .clock(clock),
    .index(acc_index),
    .write(process),
    .load (first_pix),
    .pixel(in_pixel),
    .sum  (acc_sum)
  );

  // A block's first pixel ignores whatever is stale in its accumulator.
  assign block_sum = first_pix ? ACC_W'(in_pixel) : acc_sum;
  assign avg       = PIX_W'((block_sum + ROUND) >> (2 * ZL));

  // Frame state and raster position registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      linha  <= '0;
      coluna <= '0;
    end else begin
      state  <= state_next;
      linha  <= linha_next;
      coluna <= coluna_next;
    end
  end

  // Advance the raster position for each processed pixel; frame end returns to IDLE.
  always_comb begin
    state_next  = state;
    linha_next  = linha;
    coluna_next = coluna;
    if (process) begin
      if (pos_c == COL_LAST) begin
        coluna_next = '0;
        if (pos_l == ROW_LAST) begin
          linha_next = '0;
          state_next = IDLE;
        end else begin
          linha_next = pos_l + ROW_W'(1);
          state_next = RUN;
        end
      end else begin
        coluna_next = pos_c + COL_W'(1);
        linha_next  = pos_l;
        state_next  = RUN;
      end
    end
  end

  // Output register: load on block completion, clear valid once transferred.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_sof   <= 1'b0;
      out_eof   <= 1'b0;
      err_sof   <= 1'b0;
    end else begin
      err_sof <= err_det;
      if (process && last_pix) begin
        out_valid <= 1'b1;
        out_pixel <= avg;
        out_sof   <= ((pos_c >> ZL) == '0) && ((pos_l >> ZL) == '0);
        out_eof   <= ((pos_c >> ZL) == BLK_COL_LAST) && ((pos_l >> ZL) == BLK_ROW_LAST);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
